// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: matrix geometry, key-code width,
// FSM state encoding and small frame helpers.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
  localparam int KEY_W    = $clog2(NUM_KEYS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HELD    = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  function automatic logic [KEY_W:0] key_count(input logic [NUM_KEYS-1:0] frame);
    logic [KEY_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      n = n + {{KEY_W{1'b0}}, frame[i]};
    end
    return n;
  endfunction

  // Only meaningful when exactly one bit is set.
  function automatic logic [KEY_W-1:0] key_index(input logic [NUM_KEYS-1:0] frame);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (frame[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kp_tick.sv
// End-of-slot strobe: tick is high on the last of every DIV enabled cycles.
module kp_tick #(
  parameter int DIV = 10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with frame debounce and ghost rejection.
// Optional auto-repeat is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 10000,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [NUM_ROWS-1:0] row,
  input  logic [NUM_COLS-1:0] col,
  output logic [KEY_W-1:0]    key,
  output logic                key_valid,
  output logic                key_down,
  output logic [1:0]          fsm_state
);

`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  localparam int SW      = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = (REP_MAX > 0) ? $clog2(REP_MAX + 1) : 1;

  logic [NUM_COLS-1:0] col_s1, col_s2;
  logic                run;
  logic                tick;
  logic [1:0]          row_idx;
  logic [NUM_KEYS-1:0] snap, prev_frame, frame_now;
  logic [SW-1:0]       stable_cnt, stable_next;
  logic                frame_close, frame_stable;
  logic [KEY_W:0]      nkeys;
  state_t              state, state_next;
  logic [KEY_W-1:0]    key_next;
  logic                pulse;
  logic [RW-1:0]       rep_cnt;
  logic                rep_first, rep_clr, rep_step, rep_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_s1 <= '1;
      col_s2 <= '1;
    end else begin
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  // run holds the rows released during reset and starts slot 0 on the first free edge.
  always_ff @(posedge clk) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  kp_tick #(.DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (run),
    .tick (tick)
  );

  assign row         = run ? ~(NUM_ROWS'(1) << row_idx) : '1;
  assign frame_close = tick && (row_idx == 2'(NUM_ROWS - 1));

  // Frame as it will look once the last row's sample lands.
  always_comb begin
    frame_now = snap;
    frame_now[(NUM_ROWS-1)*NUM_COLS +: NUM_COLS] = ~col_s2;
  end

  always_comb begin
    if (frame_now == prev_frame) begin
      stable_next = (stable_cnt == SW'(DEBOUNCE)) ? stable_cnt : stable_cnt + 1'b1;
    end else begin
      stable_next = '0;
    end
  end

  assign frame_stable = (stable_next == SW'(DEBOUNCE));
  assign nkeys        = key_count(frame_now);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_idx    <= '0;
      snap       <= '0;
      prev_frame <= '0;
      stable_cnt <= '0;
    end else if (tick) begin
      row_idx <= row_idx + 1'b1;
      snap[{row_idx, 2'b00} +: NUM_COLS] <= ~col_s2;
      if (frame_close) begin
        prev_frame <= frame_now;
        stable_cnt <= stable_next;
      end
    end
  end

  assign rep_hit = rep_first ? (int'(rep_cnt) + 1 == REPEAT_DELAY)
                             : (int'(rep_cnt) + 1 == REPEAT_RATE);

  always_comb begin
    state_next = state;
    key_next   = key;
    pulse      = 1'b0;
    rep_clr    = 1'b0;
    rep_step   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_close && frame_stable) begin
          if (nkeys == (KEY_W+1)'(1)) begin
            state_next = HELD;
            key_next   = key_index(frame_now);
            pulse      = 1'b1;
            rep_clr    = 1'b1;
          end else if (nkeys > (KEY_W+1)'(1)) begin
            state_next = BLOCKED;
          end
        end
      end
      HELD: begin
        if (frame_close) begin
          if (frame_stable && frame_now == '0) begin
            state_next = IDLE;
          end else if (frame_stable && frame_now != (NUM_KEYS'(1) << key)) begin
            state_next = BLOCKED;
          end else begin
            rep_step = 1'b1;
            pulse    = REPEAT_EN && rep_hit;
          end
        end
      end
      BLOCKED: begin
        if (frame_close && frame_stable && frame_now == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      key       <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_next;
      key       <= key_next;
      key_valid <= pulse;
      key_down  <= (state_next == HELD);
    end
  end

  // Counts frames since HELD entry, then since the last repeat pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_clr) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (rep_step) begin
      if (rep_hit) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

  assign fsm_state = state;

endmodule
